// File: rtl/boot_seq_pkg.sv
// Shared types and constants for the FPGA boot sequencer.
//   boot_state_e : FSM state encoding, also exported on state_o for ILA/debug
//   WdtCntWidth  : width of the saturating watchdog timeout counter
package boot_seq_pkg;

  typedef enum logic [2:0] {
    StWaitLock  = 3'd0,
    StHoldRst   = 3'd1,
    StWaitFetch = 3'd2,
    StRun       = 3'd3,
    StDone      = 3'd4
  } boot_state_e;

  localparam int unsigned WdtCntWidth = 8;

endpackage

// File: rtl/boot_seq_timer.sv
// Shared cycle counter for the boot sequencer's timed states.
//   clk_i, rst_ni : clock and synchronous active-low reset
//   clr_i         : restart the count at zero (wins over en_i)
//   en_i          : count one per cycle
//   sat_i         : hold the count once it reaches limit_i
//   limit_i       : runtime terminal value (state length minus one)
//   tc_o          : count equals limit_i
module boot_seq_timer #(
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic                sat_i,
  input  logic [CntWidth-1:0] limit_i,
  output logic                tc_o
);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == limit_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !(sat_i && tc_o)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fpga_boot_seq.sv
// Boot/reset sequencer for the FPGA top level. Waits for a stable clock lock, holds the SoC
// in reset, releases it, then enables instruction fetch after a delay once fetch is
// permitted. Lock loss or a debug reset request re-sequences the SoC.
// Optional feature: define BOOT_SEQ_WDT_EN for a RUN-state watchdog that restarts the SoC
// when status_i does not arrive within WdtCycles, counting timeouts on wdt_timeouts_o.
// Ports:
//   clk_i, rst_ni   : clock and synchronous active-low reset
//   locked_i        : clock generator lock
//   sw_reset_i      : debug reset request (level, rising edge acts)
//   fetch_req_i     : fetch permission (level)
//   status_i        : SoC completion flag
//   soc_rst_no      : SoC reset, active low
//   fetch_en_o      : SoC fetch enable
//   done_o          : sticky SoC completion
//   state_o         : current FSM state
//   wdt_timeouts_o  : saturating watchdog timeout count
module fpga_boot_seq
  import boot_seq_pkg::*;
#(
  parameter int unsigned LockStableCycles = 1024,
  parameter int unsigned RstHoldCycles    = 16,
  parameter int unsigned FetchDelayCycles = 64,
  parameter int unsigned WdtCycles        = 65535,
  parameter int unsigned CntWidth         = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   locked_i,
  input  logic                   sw_reset_i,
  input  logic                   fetch_req_i,
  input  logic                   status_i,
  output logic                   soc_rst_no,
  output logic                   fetch_en_o,
  output logic                   done_o,
  output logic [2:0]             state_o,
  output logic [WdtCntWidth-1:0] wdt_timeouts_o
);

  localparam longint unsigned MaxCycles = (64'd1 << CntWidth) - 64'd1;

  if (LockStableCycles < 1 || 64'(LockStableCycles) > MaxCycles ||
      RstHoldCycles < 1    || 64'(RstHoldCycles) > MaxCycles    ||
      FetchDelayCycles < 1 || 64'(FetchDelayCycles) > MaxCycles ||
      WdtCycles < 1        || 64'(WdtCycles) > MaxCycles) begin : gen_bad_param
    $fatal(1, "fpga_boot_seq: every *Cycles parameter must be in [1, 2**CntWidth-1]");
  end

  localparam logic [CntWidth-1:0] LockLim  = CntWidth'(LockStableCycles - 1);
  localparam logic [CntWidth-1:0] RstLim   = CntWidth'(RstHoldCycles - 1);
  localparam logic [CntWidth-1:0] FetchLim = CntWidth'(FetchDelayCycles - 1);
`ifdef BOOT_SEQ_WDT_EN
  localparam logic [CntWidth-1:0] WdtLim   = CntWidth'(WdtCycles - 1);
`endif

  boot_state_e         state_q, state_d;
  logic                sw_reset_q;
  logic                sw_edge;
  logic                restart;
  logic                tmr_en;
  logic                tmr_sat;
  logic                tc;
  logic [CntWidth-1:0] limit;
`ifdef BOOT_SEQ_WDT_EN
  logic                   wdt_fire;
  logic [WdtCntWidth-1:0] wdt_q;
`endif

  assign sw_edge = sw_reset_i & ~sw_reset_q;
  assign state_o = state_q;

  always_comb begin
    state_d  = state_q;
    restart  = 1'b0;
    limit    = '0;
    tmr_en   = 1'b0;
    tmr_sat  = 1'b0;
`ifdef BOOT_SEQ_WDT_EN
    wdt_fire = 1'b0;
`endif
    unique case (state_q)
      StWaitLock: begin
        limit  = LockLim;
        tmr_en = locked_i;
        // Any low cycle restarts the stability window.
        if (!locked_i) begin
          restart = 1'b1;
        end else if (tc) begin
          state_d = StHoldRst;
        end
      end
      StHoldRst: begin
        limit  = RstLim;
        tmr_en = 1'b1;
        if (tc) state_d = StWaitFetch;
      end
      StWaitFetch: begin
        limit   = FetchLim;
        tmr_en  = 1'b1;
        tmr_sat = 1'b1;
        if (tc && fetch_req_i) state_d = StRun;
      end
      StRun: begin
`ifdef BOOT_SEQ_WDT_EN
        limit  = WdtLim;
        tmr_en = 1'b1;
        if (status_i) begin
          state_d = StDone;
        end else if (tc) begin
          state_d  = StHoldRst;
          wdt_fire = 1'b1;
        end
`else
        if (status_i) state_d = StDone;
`endif
      end
      StDone: begin
      end
      default: state_d = StWaitLock;
    endcase

    // Re-sequence events override the normal transition; lock loss first.
    if (state_q != StWaitLock) begin
      if (!locked_i) begin
        state_d = StWaitLock;
        restart = 1'b1;
`ifdef BOOT_SEQ_WDT_EN
        wdt_fire = 1'b0;
`endif
      end else if (sw_edge) begin
        // Also covers HOLD_RST -> HOLD_RST, which must restart the hold window.
        state_d = StHoldRst;
        restart = 1'b1;
`ifdef BOOT_SEQ_WDT_EN
        wdt_fire = 1'b0;
`endif
      end
    end

    if (state_d != state_q) restart = 1'b1;
  end

  boot_seq_timer #(
    .CntWidth(CntWidth)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (restart),
    .en_i    (tmr_en),
    .sat_i   (tmr_sat),
    .limit_i (limit),
    .tc_o    (tc)
  );

  // Outputs are decoded from the next state so they change on the entry edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StWaitLock;
      sw_reset_q <= 1'b0;
      soc_rst_no <= 1'b0;
      fetch_en_o <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sw_reset_q <= sw_reset_i;
      soc_rst_no <= (state_d == StWaitFetch) || (state_d == StRun) || (state_d == StDone);
      fetch_en_o <= (state_d == StRun) || (state_d == StDone);
      if (state_d == StDone) begin
        done_o <= 1'b1;
      end else if ((state_d == StWaitLock) || (state_d == StHoldRst)) begin
        done_o <= 1'b0;
      end
    end
  end

`ifdef BOOT_SEQ_WDT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wdt_q <= '0;
    end else if (wdt_fire && (wdt_q != '1)) begin
      wdt_q <= wdt_q + 1'b1;
    end
  end

  assign wdt_timeouts_o = wdt_q;
`else
  assign wdt_timeouts_o = '0;
`endif

endmodule

// File: tb/tb_fpga_boot_seq.sv
// Directed testbench for fpga_boot_seq with small timing parameters
// (lock 8, hold 4, fetch delay 6, watchdog 20). Inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point, so "cycle k" is the k-th edge after a step.
module tb_fpga_boot_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       sw_reset;
  logic       fetch_req;
  logic       status;
  logic       soc_rst_n;
  logic       fetch_en;
  logic       done;
  logic [2:0] state;
  logic [7:0] wdt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fpga_boot_seq #(
    .LockStableCycles (8),
    .RstHoldCycles    (4),
    .FetchDelayCycles (6),
    .WdtCycles        (20),
    .CntWidth         (16)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .locked_i       (locked),
    .sw_reset_i     (sw_reset),
    .fetch_req_i    (fetch_req),
    .status_i       (status),
    .soc_rst_no     (soc_rst_n),
    .fetch_en_o     (fetch_en),
    .done_o         (done),
    .state_o        (state),
    .wdt_timeouts_o (wdt)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int st, input int rst, input int fe,
                         input int dn);
    chk({tag, ".state"}, 32'(state), st);
    chk({tag, ".soc_rst_n"}, 32'(soc_rst_n), rst);
    chk({tag, ".fetch_en"}, 32'(fetch_en), fe);
    chk({tag, ".done"}, 32'(done), dn);
  endtask

  initial begin
    int st;
    rst_n     = 1'b0;
    locked    = 1'b0;
    sw_reset  = 1'b0;
    fetch_req = 1'b0;
    status    = 1'b0;
    tick(3);
    chk_out("reset", 0, 0, 0, 0);
    chk("reset.wdt", 32'(wdt), 0);

    // Cold boot: HOLD_RST at 8, reset release at 12, fetch at 18.
    rst_n     = 1'b1;
    locked    = 1'b1;
    fetch_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      st = (k < 8) ? 0 : (k < 12) ? 1 : (k < 18) ? 2 : 3;
      chk($sformatf("cold%0d.state", k), 32'(state), st);
      chk($sformatf("cold%0d.rst", k), 32'(soc_rst_n), (st >= 2) ? 1 : 0);
      chk($sformatf("cold%0d.fe", k), 32'(fetch_en), (st >= 3) ? 1 : 0);
    end

    // Dropping fetch_req in RUN keeps fetch enabled.
    fetch_req = 1'b0;
    tick(3);
    chk_out("run_hold", 3, 1, 1, 0);

    // Single-cycle status pulse -> DONE, sticky.
    status = 1'b1;
    tick(1);
    chk_out("done_enter", 4, 1, 1, 1);
    status = 1'b0;
    tick(5);
    chk_out("done_sticky", 4, 1, 1, 1);

    // sw_reset held 10 cycles -> exactly one 4-cycle HOLD_RST, then WAIT_FETCH.
    sw_reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      st = (k <= 4) ? 1 : 2;
      chk($sformatf("swrst%0d.state", k), 32'(state), st);
      chk($sformatf("swrst%0d.rst", k), 32'(soc_rst_n), (st == 2) ? 1 : 0);
      chk($sformatf("swrst%0d.fe", k), 32'(fetch_en), 0);
      chk($sformatf("swrst%0d.done", k), 32'(done), 0);
    end
    sw_reset = 1'b0;

    // Late fetch: 20 cycles into WAIT_FETCH, then request.
    tick(14);
    chk_out("late_wait", 2, 1, 0, 0);
    fetch_req = 1'b1;
    tick(1);
    chk_out("late_fetch", 3, 1, 1, 0);
    fetch_req = 1'b0;
    tick(2);
    chk_out("late_hold", 3, 1, 1, 0);

    // Lock loss in RUN drops everything on the next edge.
    locked = 1'b0;
    tick(1);
    chk_out("lockloss", 0, 0, 0, 0);
    tick(2);
    chk("lockloss_stay", 32'(state), 0);

    // Lock glitch at cycle 5 of WAIT_LOCK restarts the 8-cycle window.
    locked = 1'b1;
    tick(5);
    chk("glitch_pre", 32'(state), 0);
    locked = 1'b0;
    tick(1);
    chk("glitch_low", 32'(state), 0);
    locked = 1'b1;
    tick(7);
    chk("glitch_wait7", 32'(state), 0);
    tick(1);
    chk_out("glitch_hold", 1, 0, 0, 0);

    // Lock loss wins over a same-cycle sw_reset edge.
    tick(4);
    chk("prio_setup", 32'(state), 2);
    locked   = 1'b0;
    sw_reset = 1'b1;
    tick(1);
    chk_out("prio", 0, 0, 0, 0);
    sw_reset = 1'b0;
    tick(1);
    sw_reset = 1'b1;
    tick(1);
    chk("swrst_in_waitlock", 32'(state), 0);
    sw_reset = 1'b0;

    // Reset mid-sequence from DONE.
    locked    = 1'b1;
    fetch_req = 1'b1;
    tick(18);
    chk("rst_setup", 32'(state), 3);
    status = 1'b1;
    tick(1);
    chk_out("rst_done", 4, 1, 1, 1);
    status = 1'b0;
    rst_n  = 1'b0;
    tick(1);
    chk_out("midreset", 0, 0, 0, 0);
    chk("midreset.wdt", 32'(wdt), 0);
    rst_n = 1'b1;

    // Watchdog scenario: status never arrives.
    tick(18);
    chk("wdt_setup", 32'(state), 3);
`ifdef BOOT_SEQ_WDT_EN
    tick(19);
    chk("wdt_run19", 32'(state), 3);
    tick(1);
    chk("wdt_first.state", 32'(state), 1);
    chk("wdt_first.cnt", 32'(wdt), 1);
    for (int i = 2; i <= 300; i++) begin
      tick(30);
      chk($sformatf("wdt%0d.state", i), 32'(state), 1);
      chk($sformatf("wdt%0d.cnt", i), 32'(wdt), (i < 255) ? i : 255);
    end
`else
    tick(40);
    chk("nowdt.state", 32'(state), 3);
    chk("nowdt.cnt", 32'(wdt), 0);
    chk("nowdt.fe", 32'(fetch_en), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
